// File: rtl/apb_cmd_pkg.sv
// Shared types and constants for the byte-stream-to-APB command initiator.
package apb_cmd_pkg;

  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_SETUP,
    S_ACCESS,
    S_STAT,
    S_RDATA
  } state_t;

  localparam int CMD_WRITE_BIT = 0;

  localparam logic [7:0] STATUS_OK      = 8'h00;
  localparam logic [7:0] STATUS_SLVERR  = 8'h01;
  localparam logic [7:0] STATUS_TIMEOUT = 8'h02;
  localparam logic [7:0] STATUS_ILLEGAL = 8'h03;

endpackage

// File: rtl/apb_cmd_master.sv
// Byte-stream command parser driving one APB read/write per command and returning status/data bytes.
// Optional access timeout is compiled in with APB_TIMEOUT_EN.
//
// state    | meaning
// S_CMD    | waiting for command byte
// S_ADDR   | collecting 4 address bytes, LSB first
// S_WDATA  | collecting 4 write-data bytes, LSB first
// S_SETUP  | APB setup phase (psel=1, penable=0)
// S_ACCESS | APB access phase, waiting for pready
// S_STAT   | presenting status byte
// S_RDATA  | presenting 4 read-data bytes, LSB first
module apb_cmd_master
  import apb_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic [3:0]  pwstrb,
  input  logic        pready,
  input  logic [31:0] prdata,
  input  logic        pslverr,
  output logic        busy
);

  state_t      state, state_nx;
  logic [1:0]  cnt;
  logic        is_write;
  logic [3:0]  strb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  status;
  logic        rx_fire, tx_fire, cmd_illegal, last_byte, tmo_hit;

  assign rx_fire     = rx_valid & rx_ready;
  assign tx_fire     = tx_valid & tx_ready;
  assign cmd_illegal = |rx_data[3:1];
  assign last_byte   = (cnt == 2'd3);

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst)                              tmo_cnt <= '0;
    else if (state == S_SETUP)            tmo_cnt <= '0;
    else if (state == S_ACCESS && !pready) tmo_cnt <= tmo_cnt + TW'(1);
  end

  // The current access cycle is counted too, so expiry lands on the TIMEOUT_CYCLES-th cycle.
  assign tmo_hit = (state == S_ACCESS) && !pready &&
                   ((tmo_cnt + TW'(1)) == TW'(TIMEOUT_CYCLES));
`else
  assign tmo_hit = 1'b0;
`endif

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_CMD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    psel     = 1'b0;
    penable  = 1'b0;
    busy     = (state != S_CMD);
    tx_data  = status;
    case (state)
      S_CMD: begin
        rx_ready = !rst;
        if (rx_fire) state_nx = cmd_illegal ? S_STAT : S_ADDR;
      end
      S_ADDR: begin
        rx_ready = !rst;
        if (rx_fire && last_byte) state_nx = is_write ? S_WDATA : S_SETUP;
      end
      S_WDATA: begin
        rx_ready = !rst;
        if (rx_fire && last_byte) state_nx = S_SETUP;
      end
      S_SETUP: begin
        psel     = 1'b1;
        state_nx = S_ACCESS;
      end
      S_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready || tmo_hit) state_nx = S_STAT;
      end
      S_STAT: begin
        tx_valid = !rst;
        if (tx_fire) state_nx = (!is_write && status == STATUS_OK) ? S_RDATA : S_CMD;
      end
      S_RDATA: begin
        tx_valid = !rst;
        tx_data  = rdata[7:0];
        if (tx_fire && last_byte) state_nx = S_CMD;
      end
      default: state_nx = S_CMD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 2'd0;
      is_write <= 1'b0;
      strb     <= 4'd0;
      addr     <= 32'd0;
      wdata    <= 32'd0;
      rdata    <= 32'd0;
      status   <= STATUS_OK;
    end else begin
      case (state)
        S_CMD: if (rx_fire) begin
          is_write <= rx_data[CMD_WRITE_BIT];
          strb     <= rx_data[7:4];
          cnt      <= 2'd0;
          status   <= cmd_illegal ? STATUS_ILLEGAL : STATUS_OK;
        end
        S_ADDR: if (rx_fire) begin
          addr <= {rx_data, addr[31:8]};
          cnt  <= cnt + 2'd1;
        end
        S_WDATA: if (rx_fire) begin
          wdata <= {rx_data, wdata[31:8]};
          cnt   <= cnt + 2'd1;
        end
        S_ACCESS: begin
          if (pready) begin
            rdata  <= prdata;
            status <= pslverr ? STATUS_SLVERR : STATUS_OK;
          end else if (tmo_hit) begin
            status <= STATUS_TIMEOUT;
          end
        end
        S_RDATA: if (tx_fire) begin
          rdata <= {8'h00, rdata[31:8]};
          cnt   <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign paddr  = addr;
  assign pwdata = wdata;
  assign pwrite = is_write;
  // Byte strobes only mean something for writes.
  assign pwstrb = is_write ? strb : 4'd0;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed scoreboard bench for apb_cmd_master; timeout scenarios run when APB_TIMEOUT_EN is defined.
module tb_apb_cmd_master;

  localparam int TMO = 8;
  localparam int LIM = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid, rx_ready, tx_valid, tx_ready;
  logic [7:0]  rx_data, tx_data;
  logic        psel, penable, pwrite, pready, pslverr, busy;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pwstrb;

  apb_cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pwstrb(pwstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [3:0]  strb;
  } apb_t;

  apb_t       apb_q[$];
  logic [7:0] tx_q[$];

  int checks = 0;
  int passes = 0;

  int          wait_cfg = 0;
  logic [31:0] prdata_cfg = 32'd0;
  bit          slverr_cfg = 1'b0;
  bit          never_ready = 1'b0;
  int          apb_setups = 0;
  int          last_acc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // APB completer model: checks each transfer against the expected queue.
  apb_t cur;
  int   acc_cnt = 0;
  always @(negedge clk) begin
    if (psel && !penable) begin
      apb_setups++;
      acc_cnt = 0;
      pready  = 1'b0;
      pslverr = 1'b0;
      if (apb_q.size() == 0) begin
        check("apb_unexpected_setup", 32'(apb_q.size()), 32'd1);
      end else begin
        cur = apb_q.pop_front();
        check("apb_paddr", paddr, cur.addr);
        check("apb_pwrite", 32'(pwrite), 32'(cur.wr));
        check("apb_pwstrb", 32'(pwstrb), 32'(cur.strb));
        if (cur.wr) check("apb_pwdata", pwdata, cur.wdata);
      end
    end else if (psel && penable) begin
      acc_cnt++;
      last_acc = acc_cnt;
      check("apb_paddr_hold", paddr, cur.addr);
      check("apb_pwrite_hold", 32'(pwrite), 32'(cur.wr));
      if (!never_ready && acc_cnt > wait_cfg) begin
        pready  = 1'b1;
        prdata  = prdata_cfg;
        pslverr = slverr_cfg;
      end else begin
        pready  = 1'b0;
        prdata  = 32'hBAD0_BAD0;
        pslverr = 1'b0;
      end
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit rand_gap);
    int n;
    @(negedge clk);
    if (rand_gap) begin
      n = $urandom_range(0, 3);
      repeat (n) begin
        rx_valid = 1'b0;
        @(negedge clk);
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < LIM) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      check("rx_accept_bound", 32'(rx_ready), 32'd1);
      rx_valid = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic send_cmd(input logic [7:0] bq[$], input bit rand_gap);
    foreach (bq[i]) send_byte(bq[i], rand_gap);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic drain(input int nbytes, input bit stall, input int exp_lat);
    int         n;
    bit         stable;
    logic [7:0] hold, exp;
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      n = 0;
      while (!tx_valid && n < LIM) begin
        @(negedge clk);
        n++;
      end
      if (!tx_valid) begin
        check("tx_valid_bound", 32'(tx_valid), 32'd1);
        return;
      end
      if (i == 0) begin
        check("psel_low_at_resp", 32'(psel), 32'd0);
        if (exp_lat >= 0) check("resp_latency", 32'(n), 32'(exp_lat));
      end
      if (tx_q.size() == 0) begin
        check("tx_unexpected_byte", 32'(tx_q.size()), 32'd1);
        exp = 8'h00;
      end else begin
        exp = tx_q.pop_front();
      end
      check("tx_byte", 32'(tx_data), 32'(exp));
      if (stall) begin
        hold   = tx_data;
        stable = 1'b1;
        repeat (10) begin
          @(negedge clk);
          if (tx_data !== hold || tx_valid !== 1'b1) stable = 1'b0;
        end
        check("tx_stall_stable", 32'(stable), 32'd1);
      end
      tx_ready = 1'b1;
      @(posedge clk);
      #1 tx_ready = 1'b0;
    end
    @(negedge clk);
    check("idle_after_resp", 32'(busy), 32'd0);
    check("tx_queue_empty", 32'(tx_q.size()), 32'd0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int w, input bit err, input bit rg, input bit stall);
    apb_t       e;
    logic [7:0] bq[$];
    e.addr = a; e.wdata = d; e.wr = 1'b1; e.strb = s;
    apb_q.push_back(e);
    wait_cfg = w; slverr_cfg = err; never_ready = 1'b0;
    tx_q.push_back(err ? 8'h01 : 8'h00);
    bq.push_back({s, 4'b0001});
    for (int i = 0; i < 4; i++) bq.push_back(8'(a >> (8 * i)));
    for (int i = 0; i < 4; i++) bq.push_back(8'(d >> (8 * i)));
    send_cmd(bq, rg);
    drain(1, stall, w + 1);
    check("apb_access_cycles", 32'(last_acc), 32'(w + 1));
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] rd, input int w,
                         input bit err, input bit nr, input bit rg, input bit stall);
    apb_t       e;
    logic [7:0] bq[$];
    logic [7:0] st;
    e.addr = a; e.wdata = 32'd0; e.wr = 1'b0; e.strb = 4'd0;
    apb_q.push_back(e);
    wait_cfg = w; slverr_cfg = err; never_ready = nr; prdata_cfg = rd;
    st = nr ? 8'h02 : (err ? 8'h01 : 8'h00);
    tx_q.push_back(st);
    if (st == 8'h00) for (int i = 0; i < 4; i++) tx_q.push_back(8'(rd >> (8 * i)));
    bq.push_back(8'h00);
    for (int i = 0; i < 4; i++) bq.push_back(8'(a >> (8 * i)));
    send_cmd(bq, rg);
    drain((st == 8'h00) ? 5 : 1, stall, nr ? TMO : w + 1);
    check("apb_access_cycles", 32'(last_acc), nr ? 32'(TMO) : 32'(w + 1));
    never_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         setups_before, n, tx_seen;
    logic [7:0] bq[$];

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    pready = 1'b0; prdata = 32'd0; pslverr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_penable", 32'(penable), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_paddr", paddr, 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rx_ready_after_rst", 32'(rx_ready), 32'd1);

    // Basic write and read with wait states.
    do_write(32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 1'b0, 1'b0);
    do_read(32'h8000_0004, 32'h1234_5678, 3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Slave error on write and on read; illegal command.
    do_write(32'h0000_0020, 32'h1122_3344, 4'h3, 1, 1'b1, 1'b0, 1'b0);
    do_read(32'h0000_0030, 32'h5555_AAAA, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    setups_before = apb_setups;
    tx_q.push_back(8'h03);
    bq = {8'h06};
    send_cmd(bq, 1'b0);
    drain(1, 1'b0, -1);
    check("illegal_no_apb", 32'(apb_setups), 32'(setups_before));

    // Random rx gaps and tx backpressure.
    do_write(32'h1234_5678, 32'hCAFE_F00D, 4'h5, 2, 1'b0, 1'b1, 1'b1);
    do_read(32'h0000_00FC, 32'hA5A5_5A5A, 0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset during the access phase.
    begin
      apb_t e;
      e.addr = 32'h4000_0000; e.wdata = 32'd0; e.wr = 1'b0; e.strb = 4'd0;
      apb_q.push_back(e);
      never_ready = 1'b1;
      bq = {8'h00, 8'h00, 8'h00, 8'h00, 8'h40};
      send_cmd(bq, 1'b0);
      n = 0;
      while (!(psel && penable) && n < LIM) begin
        @(negedge clk);
        n++;
      end
      check("reach_access", 32'(penable), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_psel", 32'(psel), 32'd0);
      check("rst_mid_penable", 32'(penable), 32'd0);
      check("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
      rst = 1'b0;
      never_ready = 1'b0;
      tx_seen = 0;
      repeat (20) begin
        @(negedge clk);
        if (tx_valid) tx_seen++;
      end
      check("rst_no_response", 32'(tx_seen), 32'd0);
      check("rst_apb_q_empty", 32'(apb_q.size()), 32'd0);
    end
    do_write(32'h0000_0008, 32'h0000_0001, 4'h1, 0, 1'b0, 1'b0, 1'b0);

`ifdef APB_TIMEOUT_EN
    do_read(32'h2000_0000, 32'h0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_read(32'h2000_0004, 32'h0BAD_F00D, TMO - 1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
